// File: rtl/bk_adder_pkg.sv
// Shared definitions for the Brent-Kung adder family: operand width and the
// associative prefix operator that every prefix cell implements.
package bk_adder_pkg;

  localparam int ADD_W = 8;

  // (gh,ph) o (gl,pl) = (gh | ph&gl, ph&pl); returns {G, P}
  function automatic logic [1:0] bk_prefix_op(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

endpackage

// File: rtl/brent_kung_adder8_if.sv
// Operand/result bundle for the 8-bit Brent-Kung adder.
interface brent_kung_adder8_if;
  import bk_adder_pkg::*;

  logic [ADD_W-1:0] A;
  logic [ADD_W-1:0] B;
  logic [ADD_W:0]   S;
  logic [ADD_W:0]   S_q;

  modport master (output A, output B, input S, input S_q);
  modport slave  (input A, input B, output S, output S_q);

endinterface

// File: rtl/bk_prefix_cell.sv
// Black prefix cell; used as a gray cell by leaving the p output unused.
module bk_prefix_cell
  import bk_adder_pkg::*;
(
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  logic [1:0] gp;

  assign gp     = bk_prefix_op(gh, ph, gl, pl);
  assign {g, p} = gp;

endmodule

// File: rtl/brent_kung_adder8.sv
// 8-bit unsigned adder on an explicit Brent-Kung prefix network, with a
// combinational sum and an asynchronously cleared registered copy.
module brent_kung_adder8
  import bk_adder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  brent_kung_adder8_if.slave  bus
);

  logic [ADD_W-1:0] g, p;
  logic [ADD_W:0]   c;
  logic [ADD_W:0]   sum_p0;
  logic [ADD_W:0]   s_p1;

  // Group terms named g_<hi>_<lo>; gray-cell P outputs land in p_unused.
  logic g_1_0, g_3_2, p_3_2, g_5_4, p_5_4, g_7_6, p_7_6;
  logic g_3_0, g_7_4, p_7_4, g_7_0;
  logic g_5_0, g_2_0, g_4_0, g_6_0;
  logic [6:0] p_unused;

  // Stage p0: bit-level generate/propagate and prefix network (combinational)
  assign g = bus.A & bus.B;
  assign p = bus.A ^ bus.B;

  bk_prefix_cell u_l1_1_0 (.gh(g[1]), .ph(p[1]), .gl(g[0]), .pl(p[0]),
                           .g(g_1_0), .p(p_unused[0]));
  bk_prefix_cell u_l1_3_2 (.gh(g[3]), .ph(p[3]), .gl(g[2]), .pl(p[2]),
                           .g(g_3_2), .p(p_3_2));
  bk_prefix_cell u_l1_5_4 (.gh(g[5]), .ph(p[5]), .gl(g[4]), .pl(p[4]),
                           .g(g_5_4), .p(p_5_4));
  bk_prefix_cell u_l1_7_6 (.gh(g[7]), .ph(p[7]), .gl(g[6]), .pl(p[6]),
                           .g(g_7_6), .p(p_7_6));

  // Low-side P of a span reaching bit 0 never influences a carry; tie it off.
  bk_prefix_cell u_l2_3_0 (.gh(g_3_2), .ph(p_3_2), .gl(g_1_0), .pl(1'b0),
                           .g(g_3_0), .p(p_unused[1]));
  bk_prefix_cell u_l2_7_4 (.gh(g_7_6), .ph(p_7_6), .gl(g_5_4), .pl(p_5_4),
                           .g(g_7_4), .p(p_7_4));

  bk_prefix_cell u_l3_7_0 (.gh(g_7_4), .ph(p_7_4), .gl(g_3_0), .pl(1'b0),
                           .g(g_7_0), .p(p_unused[2]));

  bk_prefix_cell u_d1_5_0 (.gh(g_5_4), .ph(p_5_4), .gl(g_3_0), .pl(1'b0),
                           .g(g_5_0), .p(p_unused[3]));

  bk_prefix_cell u_d2_2_0 (.gh(g[2]), .ph(p[2]), .gl(g_1_0), .pl(1'b0),
                           .g(g_2_0), .p(p_unused[4]));
  bk_prefix_cell u_d2_4_0 (.gh(g[4]), .ph(p[4]), .gl(g_3_0), .pl(1'b0),
                           .g(g_4_0), .p(p_unused[5]));
  bk_prefix_cell u_d2_6_0 (.gh(g[6]), .ph(p[6]), .gl(g_5_0), .pl(1'b0),
                           .g(g_6_0), .p(p_unused[6]));

  assign c = {g_7_0, g_6_0, g_5_0, g_4_0, g_3_0, g_2_0, g_1_0, g[0], 1'b0};

  assign sum_p0 = {c[ADD_W], p ^ c[ADD_W-1:0]};
  assign bus.S  = sum_p0;

  // Stage p1: registered sum for pipelined consumers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_p1 <= '0;
    else        s_p1 <= sum_p0;
  end

  assign bus.S_q = s_p1;

endmodule

// File: tb/tb_brent_kung_adder8.sv
// Scoreboard bench for brent_kung_adder8: corner sums, random and exhaustive
// sweeps of the combinational path, and the reset behaviour of S_q.
module tb_brent_kung_adder8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [8:0] exp_q[$];

  brent_kung_adder8_if bus ();

  brent_kung_adder8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operand pair, queue its golden sum, then check S 1 ns later.
  task automatic apply_and_check(input logic [7:0] a, input logic [7:0] b,
                                 input string name);
    logic [8:0] expv;
    bus.A = a;
    bus.B = b;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    #1;
    expv = exp_q.pop_front();
    checks++;
    if (bus.S !== expv) begin
      errors++;
      $display("FAIL %s: A=%h B=%h S=%h expected %h", name, a, b, bus.S, expv);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.A  = 8'h00;
    bus.B  = 8'h00;
    #1;
    checks++;
    if (bus.S_q !== 9'h000) begin
      errors++;
      $display("FAIL reset_sq: S_q=%h expected 000", bus.S_q);
    end
    apply_and_check(8'h00, 8'h00, "reset_zero_sum");
  endtask

  task automatic test_corners();
    apply_and_check(8'h00, 8'h00, "zero");
    apply_and_check(8'hFF, 8'h01, "ripple_ff_01");
    apply_and_check(8'hFF, 8'hFF, "max_ff_ff");
    apply_and_check(8'h55, 8'hAA, "all_propagate");
    apply_and_check(8'h80, 8'h80, "msb_carry");
    apply_and_check(8'h01, 8'hFF, "ripple_01_ff");
    apply_and_check(8'h7F, 8'h01, "mid_ripple");
    apply_and_check(8'h0F, 8'h01, "low_nibble");
  endtask

  task automatic test_random();
    for (int n = 0; n < 100000; n++)
      apply_and_check(8'($urandom), 8'($urandom), "random");
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        apply_and_check(8'(a), 8'(b), "exhaustive");
  endtask

  task automatic test_register();
    rst_n = 1'b0;
    apply_and_check(8'h0F, 8'h01, "reg_s_in_reset");
    @(posedge clk);
    #1;
    checks++;
    if (bus.S_q !== 9'h000) begin
      errors++;
      $display("FAIL reg_held_in_reset: S_q=%h expected 000", bus.S_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.S_q !== 9'h010) begin
      errors++;
      $display("FAIL reg_first_load: S_q=%h expected 010", bus.S_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.S_q !== 9'h000) begin
      errors++;
      $display("FAIL reg_async_clear: S_q=%h expected 000", bus.S_q);
    end
    checks++;
    if (bus.S !== 9'h010) begin
      errors++;
      $display("FAIL reg_s_unchanged: S=%h expected 010", bus.S);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_and_check(8'hFF, 8'h01, "reg_reload_s");
    @(posedge clk);
    #1;
    checks++;
    if (bus.S_q !== 9'h100) begin
      errors++;
      $display("FAIL reg_reload: S_q=%h expected 100", bus.S_q);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_corners();
    test_random();
    test_exhaustive();
    test_register();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
